// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and defaults for the data-memory access controller.
package mem_ctrl_pkg;
    localparam int MEM_DEPTH    = 51200;
    localparam int MEM_ADDR_W   = 16;
    localparam int MEM_DATA_W   = 32;
    localparam int MEM_READ_LAT = 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response port plus single-port memory bus.
interface mem_access_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              mem_en;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_en, mem_wen, mem_addr, mem_din
    );
    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_en, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time load/store initiator for a single-port data memory,
// with address range check and a read-latency wait before the response pulse.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int DEPTH    = MEM_DEPTH,
    parameter int READ_LAT = MEM_READ_LAT
) (
    input logic clk,
    input logic rst,
    mem_access_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(READ_LAT + 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              wr, wr_nxt;
    logic              accept, legal;
    logic              mem_en_nxt, mem_wen_nxt, resp_valid_nxt, resp_err_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_din_nxt, resp_rdata_nxt;

    assign bus.req_ready = state == IDLE;
    assign accept        = bus.req_valid && bus.req_ready;
    assign legal         = bus.req_addr < ADDR_W'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            wr             <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_wen    <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_din    <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            wr             <= wr_nxt;
            bus.mem_en     <= mem_en_nxt;
            bus.mem_wen    <= mem_wen_nxt;
            bus.mem_addr   <= mem_addr_nxt;
            bus.mem_din    <= mem_din_nxt;
            bus.resp_valid <= resp_valid_nxt;
            bus.resp_rdata <= resp_rdata_nxt;
            bus.resp_err   <= resp_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = legal ? ISSUE : RESP;
            ISSUE:   state_nxt = wr ? RESP : WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so this computes their values for the next cycle.
    always_comb begin
        mem_en_nxt     = accept && legal;
        mem_wen_nxt    = mem_en_nxt && bus.req_wen;
        mem_addr_nxt   = mem_en_nxt ? bus.req_addr : bus.mem_addr;
        mem_din_nxt    = mem_en_nxt ? bus.req_wdata : bus.mem_din;
        wr_nxt         = mem_en_nxt ? bus.req_wen : wr;
        cnt_nxt        = state == ISSUE ? CNT_W'(READ_LAT - 1)
                       : (state == WAIT && cnt != '0) ? cnt - 1'b1 : cnt;
        resp_valid_nxt = state_nxt == RESP;
        resp_err_nxt   = accept && !legal;
        resp_rdata_nxt = (state == WAIT && cnt == '0) ? bus.mem_dout : '0;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: drives READ_LAT=1 and READ_LAT=2 controllers against a latency-accurate
// memory and checks every response against a timing/data reference model.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wen = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if ia();
    mem_access_ctrl_if ib();

    mem_access_ctrl #(.READ_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
    mem_access_ctrl #(.READ_LAT(2)) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

    assign ia.req_valid = req_valid && !sel;
    assign ib.req_valid = req_valid && sel;
    assign ia.req_wen   = req_wen;
    assign ib.req_wen   = req_wen;
    assign ia.req_addr  = req_addr;
    assign ib.req_addr  = req_addr;
    assign ia.req_wdata = req_wdata;
    assign ib.req_wdata = req_wdata;

    // Memory whose read data is valid only in the window READ_LAT cycles after the en edge.
    logic [31:0] mem_a [65536];
    logic [31:0] mem_b [65536];
    logic [31:0] a_p1, b_p1, b_p2;
    always @(posedge clk) begin
        if (ia.mem_en && ia.mem_wen) mem_a[ia.mem_addr] <= ia.mem_din;
        a_p1 <= (ia.mem_en && !ia.mem_wen) ? mem_a[ia.mem_addr] : $urandom;
        if (ib.mem_en && ib.mem_wen) mem_b[ib.mem_addr] <= ib.mem_din;
        b_p1 <= (ib.mem_en && !ib.mem_wen) ? mem_b[ib.mem_addr] : $urandom;
        b_p2 <= b_p1;
    end
    assign ia.mem_dout = a_p1;
    assign ib.mem_dout = b_p2;

    logic        o_ready, o_en, o_wen, o_rv, o_err;
    logic [15:0] o_addr;
    logic [31:0] o_din, o_rd;
    assign o_ready = sel ? ib.req_ready  : ia.req_ready;
    assign o_en    = sel ? ib.mem_en     : ia.mem_en;
    assign o_wen   = sel ? ib.mem_wen    : ia.mem_wen;
    assign o_addr  = sel ? ib.mem_addr   : ia.mem_addr;
    assign o_din   = sel ? ib.mem_din    : ia.mem_din;
    assign o_rv    = sel ? ib.resp_valid : ia.resp_valid;
    assign o_err   = sel ? ib.resp_err   : ia.resp_err;
    assign o_rd    = sel ? ib.resp_rdata : ia.resp_rdata;

    logic [31:0] ref_m [int];

    function automatic int lat_of(input bit s);
        return s ? 2 : 1;
    endfunction

    function automatic int key(input bit s, input logic [15:0] a);
        return (s ? 65536 : 0) + int'(a);
    endfunction

    task automatic run_txn(input bit s, input bit w, input logic [15:0] ad, input logic [31:0] d);
        bit          err;
        int          el, ens, n;
        logic [31:0] er;
        err = ad >= 16'd51200;
        el  = err ? 1 : w ? 2 : lat_of(s) + 2;
        er  = (err || w) ? 32'd0 : ref_m[key(s, ad)];
        sel = s; req_wen = w; req_addr = ad; req_wdata = d; req_valid = 1'b1;
        #1;
        n = 0;
        while (!o_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (o_ready !== 1'b1) begin
            bad++; $display("FAIL accept_timeout ready=%b want=1", o_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        ens = 0;
        for (int c = 1; c <= el + 1; c++) begin
            ens += int'(o_en);
            total++;
            if (o_wen && !o_en) begin
                bad++; $display("FAIL wen_without_en cycle=%0d en=%b wen=%b", c, o_en, o_wen);
            end
            if (c == 1 && !err) begin
                total++;
                if ({o_en, o_wen, o_addr, o_din} !== {1'b1, w, ad, d}) begin
                    bad++;
                    $display("FAIL issue en/wen/addr/din got=%b/%b/%h/%h want=1/%b/%h/%h",
                             o_en, o_wen, o_addr, o_din, w, ad, d);
                end
            end
            total++;
            if (o_ready !== (c > el)) begin
                bad++; $display("FAIL ready cycle=%0d got=%b want=%b", c, o_ready, c > el);
            end
            total++;
            if (c == el) begin
                if ({o_rv, o_err, o_rd} !== {1'b1, err, er}) begin
                    bad++;
                    $display("FAIL resp addr=%h valid/err/rdata got=%b/%b/%h want=1/%b/%h",
                             ad, o_rv, o_err, o_rd, err, er);
                end
            end else if ({o_rv, o_err, o_rd} !== {1'b0, 1'b0, 32'd0}) begin
                bad++;
                $display("FAIL resp_quiet cycle=%0d valid/err/rdata got=%b/%b/%h want=0/0/0",
                         c, o_rv, o_err, o_rd);
            end
            @(posedge clk); #1;
        end
        total++;
        if (ens != (err ? 0 : 1)) begin
            bad++; $display("FAIL en_pulses addr=%h got=%0d want=%0d", ad, ens, err ? 0 : 1);
        end
        if (w && !err) ref_m[key(s, ad)] = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        total++;
        if ({ia.mem_en, ia.resp_valid, ia.req_ready, ib.mem_en, ib.resp_valid, ib.req_ready} !== 6'b001001) begin
            bad++;
            $display("FAIL reset_ctrl got=%b%b%b%b%b%b want=001001", ia.mem_en, ia.resp_valid,
                     ia.req_ready, ib.mem_en, ib.resp_valid, ib.req_ready);
        end
        total++;
        if ({ia.mem_wen, ia.mem_addr, ia.mem_din, ia.resp_rdata, ia.resp_err} !== 82'd0) begin
            bad++;
            $display("FAIL reset_regs wen/addr/din/rdata/err got=%b/%h/%h/%h/%b want=0",
                     ia.mem_wen, ia.mem_addr, ia.mem_din, ia.resp_rdata, ia.resp_err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_write_read(input bit s);
        run_txn(s, 1'b1, 16'd5, 32'd4);
        run_txn(s, 1'b0, 16'd5, 32'd0);
    endtask

    task automatic test_boundary(input bit s);
        run_txn(s, 1'b1, 16'd51199, $urandom);
        run_txn(s, 1'b0, 16'd51199, 32'd0);
        run_txn(s, 1'b0, 16'd51201, 32'd0);
        run_txn(s, 1'b1, 16'd51200, $urandom);
        run_txn(s, 1'b0, 16'hFFFF, 32'd0);
    endtask

    task automatic test_back_to_back(input bit s);
        int l;
        logic want;
        l = lat_of(s);
        sel = s; req_wen = 1'b1; req_addr = 16'd0; req_wdata = 32'd1; req_valid = 1'b1;
        #1;
        @(posedge clk); #1;
        req_wen = 1'b0; req_wdata = 32'd0;
        for (int c = 1; c <= l + 6; c++) begin
            want = (c == 3) || (c > l + 5);
            total++;
            if (o_ready !== want) begin
                bad++; $display("FAIL b2b_ready cycle=%0d got=%b want=%b", c, o_ready, want);
            end
            if (c == 1 || c == 4) begin
                total++;
                if ({o_en, o_wen, o_addr} !== {1'b1, c == 1, 16'd0}) begin
                    bad++;
                    $display("FAIL b2b_issue cycle=%0d en/wen/addr got=%b/%b/%h want=1/%b/0000",
                             c, o_en, o_wen, o_addr, c == 1);
                end
            end
            if (c == 4) req_valid = 1'b0;
            total++;
            if (c == 2 || c == l + 5) begin
                if ({o_rv, o_err, o_rd} !== {1'b1, 1'b0, 32'(c != 2)}) begin
                    bad++;
                    $display("FAIL b2b_resp cycle=%0d valid/err/rdata got=%b/%b/%h want=1/0/%h",
                             c, o_rv, o_err, o_rd, 32'(c != 2));
                end
            end else if (o_rv !== 1'b0) begin
                bad++; $display("FAIL b2b_quiet cycle=%0d valid got=%b want=0", c, o_rv);
            end
            @(posedge clk); #1;
        end
        ref_m[key(s, 16'd0)] = 32'd1;
    endtask

    task automatic test_reset_mid_op(input bit s, input int cyc);
        sel = s; req_wen = 1'b0; req_addr = 16'd0; req_valid = 1'b1;
        #1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if (o_en !== 1'b1) begin
            bad++; $display("FAIL midrst_issue en got=%b want=1", o_en);
        end
        if (cyc == 2) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({o_en, o_rv, o_ready} !== 3'b001) begin
            bad++; $display("FAIL midrst_async en/valid/ready got=%b/%b/%b want=0/0/1", o_en, o_rv, o_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            total++;
            if (o_rv !== 1'b0) begin
                bad++; $display("FAIL midrst_dropped cycle=%0d valid got=%b want=0", c, o_rv);
            end
            @(posedge clk); #1;
        end
        run_txn(s, 1'b0, 16'd0, 32'd0);
    endtask

    task automatic test_random(input bit s);
        int          r;
        bit          w;
        logic [15:0] ad;
        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(0, 9);
            ad = r < 6 ? 16'($urandom_range(0, 15)) : r < 7 ? 16'd51199 : r < 8 ? 16'd51200
               : 16'($urandom_range(51200, 65535));
            w  = 1'($urandom_range(0, 1));
            if (!w && ad < 16'd51200 && !ref_m.exists(key(s, ad))) w = 1'b1;
            run_txn(s, w, ad, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        #2;
        test_reset();
        test_write_read(1'b0);
        test_write_read(1'b1);
        test_boundary(1'b0);
        test_boundary(1'b1);
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_reset_mid_op(1'b0, 1);
        test_reset_mid_op(1'b0, 2);
        test_reset_mid_op(1'b1, 2);
        test_random(1'b0);
        test_random(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
